// File: rtl/btb_write_ctrl.sv
// rtl/btb_write_ctrl.sv - BTB write-port controller: invalidation sweep, update forwarding, one-deep hold buffer
// Sole driver of the BTB write port; sweeps all entries invalid after reset or flush.
module btb_write_ctrl #(
  parameter int                NUM_ENTRIES = 256,
  parameter int                IDX_W       = 8,
  parameter int                TGT_W       = 32,
  parameter logic [TGT_W-1:0] INIT_TARGET = '0
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   flush_req,
  input  logic                   upd_valid,
  input  logic [31:0]            upd_pc,
  input  logic [TGT_W-1:0]       upd_target,
  output logic                   upd_ready,
  output logic                   btb_we,
  output logic [IDX_W-1:0]       btb_waddr,
  output logic [IDX_W+TGT_W-1:0] btb_wdata,
  output logic                   busy,
  output logic                   sweep_done
);

  typedef enum logic [1:0] {SWEEP, DRAIN, RUN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  state_t                 state, state_n;
  logic [IDX_W-1:0]       ptr, ptr_n;
  logic                   buf_valid, buf_valid_n;
  logic [IDX_W-1:0]       buf_idx, buf_idx_n;
  logic [TGT_W-1:0]       buf_tgt, buf_tgt_n;
  logic                   we_n, done_n, accept;
  logic [IDX_W-1:0]       waddr_n, upd_idx;
  logic [IDX_W+TGT_W-1:0] wdata_n;

  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign upd_ready = (state == RUN && !flush_req) || !buf_valid;
  assign accept    = upd_valid && upd_ready;
  assign busy      = (state != RUN);

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    buf_valid_n = buf_valid;
    buf_idx_n   = buf_idx;
    buf_tgt_n   = buf_tgt;
    we_n        = 1'b0;
    waddr_n     = btb_waddr;
    wdata_n     = btb_wdata;
    done_n      = 1'b0;

    // Anything accepted while a sweep is running or about to start is parked until the sweep ends.
    if (accept && (state != RUN || flush_req)) begin
      buf_valid_n = 1'b1;
      buf_idx_n   = upd_idx;
      buf_tgt_n   = upd_target;
    end

    case (state)
      SWEEP: begin
        we_n    = 1'b1;
        waddr_n = ptr;
        wdata_n = {~ptr, INIT_TARGET};
        if (flush_req) begin
          ptr_n = '0;
        end else begin
          ptr_n = ptr + 1'b1;
          if (ptr == LAST_IDX) begin
            done_n  = 1'b1;
            state_n = buf_valid_n ? DRAIN : RUN;
          end
        end
      end
      DRAIN: begin
        buf_valid_n = 1'b0;
        if (flush_req) begin
          state_n = SWEEP;
          ptr_n   = '0;
        end else begin
          we_n    = 1'b1;
          waddr_n = buf_idx;
          wdata_n = {buf_idx, buf_tgt};
          state_n = RUN;
        end
      end
      RUN: begin
        if (flush_req) begin
          state_n = SWEEP;
          ptr_n   = '0;
        end else if (upd_valid) begin
          we_n    = 1'b1;
          waddr_n = upd_idx;
          wdata_n = {upd_idx, upd_target};
        end
      end
      default: begin
        state_n = SWEEP;
        ptr_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state      <= SWEEP;
      ptr        <= '0;
      buf_valid  <= 1'b0;
      buf_idx    <= '0;
      buf_tgt    <= '0;
      btb_we     <= 1'b0;
      btb_waddr  <= '0;
      btb_wdata  <= '0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      buf_valid  <= buf_valid_n;
      buf_idx    <= buf_idx_n;
      buf_tgt    <= buf_tgt_n;
      btb_we     <= we_n;
      btb_waddr  <= waddr_n;
      btb_wdata  <= wdata_n;
      sweep_done <= done_n;
    end
  end

endmodule

// File: tb/tb_btb_write_ctrl.sv
// tb/tb_btb_write_ctrl.sv - self-checking bench for btb_write_ctrl
// Vector table, directed corner sequences and a random run against an expected-write-queue model.
module tb_btb_write_ctrl;

  logic        clk, rst_i, flush_req, upd_valid;
  logic [31:0] upd_pc, upd_target;
  logic        upd_ready, btb_we, busy, sweep_done;
  logic [7:0]  btb_waddr;
  logic [39:0] btb_wdata;

  int checks = 0;
  int errors = 0;

  btb_write_ctrl dut (
    .clk(clk), .rst_i(rst_i), .flush_req(flush_req), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_ready(upd_ready),
    .btb_we(btb_we), .btb_waddr(btb_waddr), .btb_wdata(btb_wdata),
    .busy(busy), .sweep_done(sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  idx;
    logic [39:0] data;
    logic        last;
    logic        is_upd;
  } went_t;

  typedef struct packed {
    logic        fl;
    logic        uv;
    logic [31:0] pc;
    logic [31:0] tg;
    logic        we;
    logic [7:0]  waddr;
    logic [39:0] wdata;
    logic        busy;
  } vec_t;

  // Model: the writes still owed to the BTB, in order; an empty queue means normal operation.
  went_t mq[$];
  logic  m_has_buf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; flush_req = 1'b0; upd_valid = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic wait_addr(input logic [7:0] k);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (btb_we && btb_waddr == k) begin
        found = 1'b1;
        break;
      end
    end
    chk("wait_addr", 64'(found), 64'(1));
  endtask

  task automatic count_to_done(output int n);
    n = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (btb_we) n++;
      if (sweep_done) break;
    end
  endtask

  task automatic fill_sweep();
    logic [7:0] i8;
    mq.delete();
    for (int i = 0; i < 256; i++) begin
      i8 = 8'(i);
      mq.push_back('{idx: i8, data: {~i8, 32'h0}, last: (i == 255), is_upd: 1'b0});
    end
  endtask

  function automatic logic model_ready(input logic fl);
    return (mq.size() == 0 && !fl) || !m_has_buf;
  endfunction

  task automatic model_edge(input logic fl, input logic uv, input logic [31:0] pc,
                            input logic [31:0] tg, output logic ew, output went_t e,
                            output logic ed);
    went_t u, f, keep;
    logic  acc;
    ew = 1'b0; ed = 1'b0; e = '0;
    acc = uv && model_ready(fl);
    u = '{idx: pc[9:2], data: {pc[9:2], tg}, last: 1'b0, is_upd: 1'b1};
    if (mq.size() == 0) begin
      if (fl) begin
        fill_sweep();
        if (acc) begin mq.push_back(u); m_has_buf = 1'b1; end
      end else if (uv) begin
        ew = 1'b1; e = u;
      end
    end else begin
      f = mq.pop_front();
      if (!f.is_upd) begin
        ew = 1'b1; e = f;
        if (acc) begin mq.push_back(u); m_has_buf = 1'b1; end
        if (fl) begin
          keep = m_has_buf ? mq[$] : '0;
          fill_sweep();
          if (m_has_buf) mq.push_back(keep);
        end else begin
          ed = f.last;
        end
      end else begin
        m_has_buf = 1'b0;
        if (fl) fill_sweep();
        else begin ew = 1'b1; e = f; end
      end
    end
  endtask

  initial begin
    vec_t        vt[6];
    int          n;
    logic        fl_r, uv_r, hold, rdy, ew, ed;
    logic [31:0] pc_r, tg_r;
    went_t       e;

    vt[0] = '{1'b0, 1'b1, 32'h0000_0124, 32'h0000_0800, 1'b1, 8'h49, 40'h49_0000_0800, 1'b0};
    vt[1] = '{1'b0, 1'b1, 32'h0000_03FC, 32'hDEAD_BEEF, 1'b1, 8'hFF, 40'hFF_DEAD_BEEF, 1'b0};
    vt[2] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'h00, 40'h0,            1'b0};
    vt[3] = '{1'b0, 1'b1, 32'h0000_0404, 32'h1234_5678, 1'b1, 8'h01, 40'h01_1234_5678, 1'b0};
    vt[4] = '{1'b0, 1'b1, 32'hFFFF_FC00, 32'h0000_0001, 1'b1, 8'h00, 40'h00_0000_0001, 1'b0};
    vt[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'h00, 40'h0,            1'b1};

    rst_i = 1'b1; flush_req = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
    tick(); tick();
    chk("rst_we", 64'(btb_we), 64'(0));
    chk("rst_waddr", 64'(btb_waddr), 64'(0));
    chk("rst_wdata", 64'(btb_wdata), 64'(0));
    chk("rst_done", 64'(sweep_done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1));
    chk("rst_ready", 64'(upd_ready), 64'(1));

    // Sweep after reset release.
    rst_i = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tick();
      chk("sweep_we", 64'(btb_we), 64'(1));
      chk("sweep_waddr", 64'(btb_waddr), 64'(i));
      chk("sweep_wdata", 64'(btb_wdata), 64'({~8'(i), 32'h0}));
      chk("sweep_done", 64'(sweep_done), 64'(i == 255));
      chk("sweep_busy", 64'(busy), 64'(i != 255));
    end
    tick();
    chk("post_sweep_we", 64'(btb_we), 64'(0));

    // Vector table in RUN.
    for (int v = 0; v < 6; v++) begin
      flush_req = vt[v].fl; upd_valid = vt[v].uv; upd_pc = vt[v].pc; upd_target = vt[v].tg;
      #1;
      chk("vec_ready", 64'(upd_ready), 64'(1));
      tick();
      flush_req = 1'b0; upd_valid = 1'b0;
      chk("vec_we", 64'(btb_we), 64'(vt[v].we));
      chk("vec_busy", 64'(busy), 64'(vt[v].busy));
      if (vt[v].we) begin
        chk("vec_waddr", 64'(btb_waddr), 64'(vt[v].waddr));
        chk("vec_wdata", 64'(btb_wdata), 64'(vt[v].wdata));
      end
    end
    count_to_done(n);
    chk("vec_flush_writes", 64'(n), 64'(256));

    // Flush and update together in RUN: full sweep then one buffered write.
    tick();
    flush_req = 1'b1; upd_valid = 1'b1; upd_pc = 32'h0000_0124; upd_target = 32'h0000_ABCD;
    tick();
    flush_req = 1'b0; upd_valid = 1'b0;
    chk("fu_no_write", 64'(btb_we), 64'(0));
    count_to_done(n);
    chk("fu_sweep_writes", 64'(n), 64'(256));
    chk("fu_busy_at_done", 64'(busy), 64'(1));
    tick();
    chk("fu_drain_we", 64'(btb_we), 64'(1));
    chk("fu_drain_waddr", 64'(btb_waddr), 64'(8'h49));
    chk("fu_drain_wdata", 64'(btb_wdata), 64'(40'h49_0000_ABCD));
    chk("fu_drain_busy", 64'(busy), 64'(0));
    tick();
    chk("fu_single_drain", 64'(btb_we), 64'(0));

    // Flush at sweep ptr 100.
    do_reset();
    wait_addr(8'd99);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("fl100_waddr", 64'(btb_waddr), 64'(100));
    tick();
    chk("fl100_restart", 64'(btb_waddr), 64'(0));
    count_to_done(n);
    chk("fl100_total", 64'(n + 102), 64'(357));

    // Update arriving at sweep cycle 10.
    do_reset();
    wait_addr(8'd9);
    upd_valid = 1'b1; upd_pc = 32'h0000_0A48; upd_target = 32'h0000_5555;
    #1;
    chk("s10_ready_in", 64'(upd_ready), 64'(1));
    tick();
    upd_valid = 1'b0;
    chk("s10_waddr", 64'(btb_waddr), 64'(10));
    for (int c = 0; c < 300; c++) begin
      chk("s10_ready_low", 64'(upd_ready), 64'(0));
      if (btb_we && btb_waddr == 8'd255) break;
      tick();
    end
    chk("s10_done", 64'(sweep_done), 64'(1));
    chk("s10_busy_hold", 64'(busy), 64'(1));
    tick();
    chk("s10_drain_we", 64'(btb_we), 64'(1));
    chk("s10_drain_waddr", 64'(btb_waddr), 64'(8'h92));
    chk("s10_drain_wdata", 64'(btb_wdata), 64'(40'h92_0000_5555));
    chk("s10_drain_busy", 64'(busy), 64'(0));
    chk("s10_drain_done", 64'(sweep_done), 64'(0));

    // Asynchronous reset at ptr 50 with the buffer full.
    do_reset();
    wait_addr(8'd5);
    upd_valid = 1'b1; upd_pc = 32'h0000_0010; upd_target = 32'h0000_7777;
    tick();
    upd_valid = 1'b0;
    wait_addr(8'd49);
    chk("ar_buf_full", 64'(upd_ready), 64'(0));
    rst_i = 1'b1;
    #1;
    chk("ar_we", 64'(btb_we), 64'(0));
    chk("ar_waddr", 64'(btb_waddr), 64'(0));
    chk("ar_wdata", 64'(btb_wdata), 64'(0));
    chk("ar_busy", 64'(busy), 64'(1));
    chk("ar_ready", 64'(upd_ready), 64'(1));
    #1;
    rst_i = 1'b0;
    tick();
    chk("ar_restart_we", 64'(btb_we), 64'(1));
    chk("ar_restart_waddr", 64'(btb_waddr), 64'(0));
    count_to_done(n);
    chk("ar_busy_done", 64'(busy), 64'(0));
    tick();
    chk("ar_no_drain", 64'(btb_we), 64'(0));

    // Random run against the model.
    do_reset();
    fill_sweep();
    m_has_buf = 1'b0;
    hold = 1'b0;
    uv_r = 1'b0; pc_r = '0; tg_r = '0;
    for (int c = 0; c < 6000; c++) begin
      fl_r = ($urandom_range(0, 499) == 0);
      if (!hold) begin
        uv_r = ($urandom_range(0, 2) == 0);
        pc_r = $urandom();
        tg_r = $urandom();
      end
      flush_req = fl_r; upd_valid = uv_r; upd_pc = pc_r; upd_target = tg_r;
      #1;
      rdy = model_ready(fl_r);
      chk("rnd_ready", 64'(upd_ready), 64'(rdy));
      hold = uv_r && !rdy;
      model_edge(fl_r, uv_r, pc_r, tg_r, ew, e, ed);
      tick();
      chk("rnd_we", 64'(btb_we), 64'(ew));
      chk("rnd_busy", 64'(busy), 64'(mq.size() != 0));
      chk("rnd_done", 64'(sweep_done), 64'(ed));
      if (ew) begin
        chk("rnd_waddr", 64'(btb_waddr), 64'(e.idx));
        chk("rnd_wdata", 64'(btb_wdata), 64'(e.data));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
